traffic_writer: RTL
===================

Name: traffic_writer

Overview:
- Traffic source on the ingress side of the 4x4 switch fabric.
- Generates bursts of tagged words and pushes them into the four input FIFOs through push0..push3 and FIFO_data_in0..FIFO_data_in3.
- Bits [data_width-1:data_width-2] of each word carry the destination output-FIFO index. Bits below that carry a per-lane sequence number, so a downstream checker can verify routing and ordering.
- Respects per-lane almost_full backpressure from the input FIFOs.

Parameters:
data_width, 10, word width; top 2 bits are destination, low data_width-2 bits are sequence payload
len_width, 5, width of burst_len; maximum words per lane is 2^len_width-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse; launches a burst when the block is in IDLE
lane_mask  input  4  bit k enables input lane k
burst_len  input  len_width  words sent on each enabled lane
dest_map  input  8  bits [2k+1:2k] give the destination index stamped on lane k words
almost_full_in  input  4  bit k is the almost_full flag of input FIFO k
push0..push3  output  1 each  registered push strobe to input FIFO k
FIFO_data_in0..FIFO_data_in3  output  data_width each  registered write data to input FIFO k
busy  output  1  high while in SEND
done  output  1  one-cycle pulse when a burst completes
words_sent  output  len_width+2  total words pushed in the current or most recent burst

Behaviour:
- Reset is synchronous and active-high. It is sampled on the rising edge of clk and has priority over all other inputs.
- On reset:
  - state = IDLE.
  - All push, FIFO_data_in, busy, done, words_sent, remaining counters, sequence counters and the round-robin pointer go to 0.
  - Reset asserted mid-burst drops push on that same edge. No partial word is emitted afterwards.
- States are IDLE, SEND and DONE.
- IDLE:
  - On start=1, latch lane_mask, burst_len and dest_map.
  - Set remaining[k] = burst_len for each enabled lane and 0 for the others.
  - Clear seq[k] and words_sent. Set rr = 0.
  - Go to SEND. If lane_mask==0 or burst_len==0, go to DONE instead.
  - Inputs other than start are ignored in IDLE. start is ignored outside IDLE.
- SEND:
  - Each cycle, search lanes rr, rr+1, rr+2, rr+3 (mod 4) for the first lane k with remaining[k]!=0 and almost_full_in[k]==0.
  - If a lane is found, on the next edge:
    - push_k = 1 and FIFO_data_in_k = {dest_map[2k+1:2k], seq[k]}.
    - seq[k] increments and wraps at 2^(data_width-2).
    - remaining[k] decrements, words_sent increments, rr = k+1 mod 4.
  - At most one push per cycle across all lanes.
  - If no lane qualifies, all push outputs are 0 and nothing changes (stall).
  - When the push being issued takes the last nonzero remaining to 0, next state = DONE.
- DONE: done=1 for exactly one cycle, then IDLE. words_sent holds its value until the next start or reset.
- Push strobes are high for one cycle per word. FIFO_data_in_k holds its last value while push_k=0.
- Latency:
  - Start sampled at edge E0; SEND is entered at E0.
  - The first push is visible after E1.
  - The last push and the DONE state are entered on the same edge. done is high the cycle after that edge.
- almost_full_in is sampled combinationally in the selection cycle. Because push is registered, one extra word can land after almost_full rises. The FIFO threshold (alto) must leave at least 1 free slot.
- busy = (state==SEND), registered.
- Simultaneous events:
  - start is held high: one burst per IDLE visit; a new burst begins only after DONE returns the block to IDLE.
  - All enabled lanes are almost_full indefinitely: the block stalls in SEND with busy=1 and no timeout.

Test Plan:
- Reset held for 2 cycles mid-burst (lane_mask=4'b1111, burst_len=8, after 5 pushes) -> next cycle state IDLE, all push=0, words_sent=0, busy=0, done never pulses.
- start with lane_mask=4'b1111, burst_len=2, dest_map=8'b11_10_01_00, almost_full_in=0 -> pushes in lane order 0,1,2,3,0,1,2,3 on consecutive cycles. Data: lane0 10'h000 then 10'h001; lane1 10'h100, 10'h101; lane2 10'h200, 10'h201; lane3 10'h300, 10'h301. done pulses 1 cycle after the 8th push, words_sent=8.
- lane_mask=4'b0101, burst_len=3, almost_full_in[0]=1 for the first 4 cycles -> lane 2 sends its 3 words first. Lane 0 resumes only after almost_full_in[0] falls. Lane 0 seq runs 0,1,2 in order, words_sent=6.
- almost_full_in=4'b1111 constantly with lane_mask=4'b0011, burst_len=4 -> busy stays 1, zero pushes, done never asserts. Releasing almost_full completes all 8 words.
- start with lane_mask=0 (and separately burst_len=0) -> no push. done pulses 2 cycles after start, words_sent=0.
- burst_len=31 on lane 0 only, followed by a second start -> seq restarts at 0 on the second burst. A start pulsed during SEND is ignored: total pushes across both bursts = 62.

Source files
------------

// File: rtl/traffic_writer.sv
// Ingress traffic source for the 4x4 fabric: pushes tagged, sequence-numbered
// bursts into the four input FIFOs with round-robin lane selection.
module traffic_writer #(
    parameter int unsigned data_width = 10,
    parameter int unsigned len_width  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             lane_mask,
    input  logic [len_width-1:0]   burst_len,
    input  logic [7:0]             dest_map,
    input  logic [3:0]             almost_full_in,
    output logic                   push0,
    output logic                   push1,
    output logic                   push2,
    output logic                   push3,
    output logic [data_width-1:0]  FIFO_data_in0,
    output logic [data_width-1:0]  FIFO_data_in1,
    output logic [data_width-1:0]  FIFO_data_in2,
    output logic [data_width-1:0]  FIFO_data_in3,
    output logic                   busy,
    output logic                   done,
    output logic [len_width+1:0]   words_sent
);

    localparam int unsigned seq_width = data_width - 2;
    localparam int unsigned cnt_width = len_width + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0][len_width-1:0]  remaining_q, remaining_d;
    logic [3:0][seq_width-1:0]  seq_q, seq_d;
    logic [3:0][1:0]            dest_q, dest_d;
    logic [3:0][data_width-1:0] data_q, data_d;
    logic [3:0]                 push_q, push_d;
    logic [cnt_width-1:0]       words_q, words_d;
    logic [1:0]                 rr_q, rr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       found;
    logic [1:0]                 sel;
    logic [1:0]                 cand;

    // Round-robin search starting at rr for a lane with work and FIFO room
    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        cand  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!found && (remaining_q[cand] != '0) && !almost_full_in[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        seq_d       = seq_q;
        dest_d      = dest_q;
        data_d      = data_q;
        push_d      = '0;
        words_d     = words_q;
        rr_d        = rr_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < 4; k++) begin
                        remaining_d[k] = lane_mask[k] ? burst_len : '0;
                    end
                    seq_d   = '0;
                    dest_d  = dest_map;
                    words_d = '0;
                    rr_d    = 2'd0;
                    if ((lane_mask == 4'd0) || (burst_len == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (found) begin
                    push_d[sel]      = 1'b1;
                    data_d[sel]      = {dest_q[sel], seq_q[sel]};
                    seq_d[sel]       = seq_q[sel] + seq_width'(1);
                    remaining_d[sel] = remaining_q[sel] - len_width'(1);
                    words_d          = words_q + cnt_width'(1);
                    rr_d             = sel + 2'd1;
                    // Last outstanding word leaves on the same edge DONE is entered
                    if (remaining_d == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SEND);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            seq_q       <= '0;
            dest_q      <= '0;
            data_q      <= '0;
            push_q      <= '0;
            words_q     <= '0;
            rr_q        <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_q       <= seq_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
            push_q      <= push_d;
            words_q     <= words_d;
            rr_q        <= rr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign push0         = push_q[0];
    assign push1         = push_q[1];
    assign push2         = push_q[2];
    assign push3         = push_q[3];
    assign FIFO_data_in0 = data_q[0];
    assign FIFO_data_in1 = data_q[1];
    assign FIFO_data_in2 = data_q[2];
    assign FIFO_data_in3 = data_q[3];
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_sent    = words_q;

endmodule
